// File: rtl/qspi_target_if.sv
// QSPI pin bundle between an initiator (master) and the qspi_target device (slave).
interface qspi_target_if;
    logic       cs_n;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic       quad;
    logic       awake;

    modport master (output cs_n, io_in, input io_out, io_oe, quad, awake);
    modport slave  (input cs_n, io_in, output io_out, io_oe, quad, awake);
endinterface

// File: rtl/qspi_target.sv
// QSPI memory target: serial/quad command, quad address/data, byte-wide internal RAM.
// Optional power-down (reset asleep, wake on 0xAB) enabled by QSPI_TARGET_PWRDN_EN.
module qspi_target #(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned READ_DELAY = 4
) (
    input logic          clk,
    input logic          reset,
    qspi_target_if.slave bus
);

`ifdef QSPI_TARGET_PWRDN_EN
    localparam logic AwakeRst = 1'b0;
`else
    localparam logic AwakeRst = 1'b1;
`endif

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StWdata, StMode, StDummy, StRdata, StIgnore
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              is_read_q, is_read_d;
    logic              half_q, half_d;
    logic [3:0]        nib_q, nib_d;
    logic [3:0]        io_out_q, io_out_d;
    logic              oe_q, oe_d;
    logic              quad_q, quad_d;
    logic              awake_q, awake_d;
    logic              armed_q, armed_d;

    logic              mem_we;
    logic              rd_start;
    logic [7:0]        cmd_next;
    logic              cmd_last;
    logic [MEM_AW+3:0] addr_shift;
    logic [7:0]        rd_byte;
    logic [7:0]        mem [2**MEM_AW];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        half_d     = half_q;
        nib_d      = nib_q;
        io_out_d   = 4'h0;
        oe_d       = 1'b0;
        quad_d     = quad_q;
        awake_d    = awake_q;
        armed_d    = armed_q;
        mem_we     = 1'b0;
        rd_start   = 1'b0;
        cmd_next   = quad_q ? {cmd_q[3:0], bus.io_in} : {cmd_q[6:0], bus.io_in[0]};
        cmd_last   = quad_q ? (cnt_q == 4'd1) : (cnt_q == 4'd7);
        addr_shift = {addr_q, bus.io_in};
        rd_byte    = mem[addr_q];

        if (bus.cs_n) begin
            // Deselect ends everything; a pending odd nibble is simply dropped.
            state_d = StIdle;
            half_d  = 1'b0;
            armed_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (armed_q) begin
                        cmd_d   = cmd_next;
                        cnt_d   = 4'd1;
                        state_d = StCmd;
                    end else begin
                        state_d = StIgnore;
                    end
                end
                StCmd: begin
                    cmd_d = cmd_next;
                    cnt_d = cnt_q + 4'd1;
                    if (cmd_last) begin
                        cnt_d   = 4'd0;
                        state_d = StIgnore;
                        if (awake_q) begin
                            case (cmd_next)
                                8'h38: begin state_d = StAddr; is_read_d = 1'b0; end
                                8'hEB: begin state_d = StAddr; is_read_d = 1'b1; end
                                8'h35: quad_d = 1'b1;
                                8'hF5: quad_d = 1'b0;
                                default: ;
                            endcase
                        end
`ifdef QSPI_TARGET_PWRDN_EN
                        if (cmd_next == 8'hAB) awake_d = 1'b1;
`endif
                    end
                end
                StAddr: begin
                    addr_d = addr_shift[MEM_AW-1:0];
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd5) begin
                        cnt_d   = 4'd0;
                        half_d  = 1'b0;
                        state_d = is_read_q ? StMode : StWdata;
                    end
                end
                StWdata: begin
                    if (half_q) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + MEM_AW'(1);
                        half_d = 1'b0;
                    end else begin
                        nib_d  = bus.io_in;
                        half_d = 1'b1;
                    end
                end
                StMode: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd1) begin
                        cnt_d = 4'd0;
                        if (READ_DELAY == 0) rd_start = 1'b1;
                        else                 state_d  = StDummy;
                    end
                end
                StDummy: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(READ_DELAY - 1)) rd_start = 1'b1;
                end
                StRdata: begin
                    oe_d = 1'b1;
                    // half_q=0: high nibble is on the pins, so the low nibble follows.
                    if (!half_q) begin
                        io_out_d = rd_byte[3:0];
                        addr_d   = addr_q + MEM_AW'(1);
                        half_d   = 1'b1;
                    end else begin
                        io_out_d = rd_byte[7:4];
                        half_d   = 1'b0;
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase

            if (rd_start) begin
                state_d  = StRdata;
                cnt_d    = 4'd0;
                oe_d     = 1'b1;
                io_out_d = rd_byte[7:4];
                half_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            cmd_q     <= 8'h00;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            half_q    <= 1'b0;
            nib_q     <= 4'h0;
            io_out_q  <= 4'h0;
            oe_q      <= 1'b0;
            quad_q    <= 1'b0;
            awake_q   <= AwakeRst;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            half_q    <= half_d;
            nib_q     <= nib_d;
            io_out_q  <= io_out_d;
            oe_q      <= oe_d;
            quad_q    <= quad_d;
            awake_q   <= awake_d;
            armed_q   <= armed_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= {nib_q, bus.io_in};
    end

    assign bus.io_out = io_out_q;
    assign bus.io_oe  = {4{oe_q}};
    assign bus.quad   = quad_q;
    assign bus.awake  = awake_q;

endmodule

// File: tb/tb_qspi_target.sv
// Self-checking bench for qspi_target: randomized transactions against a byte-array model.
// Define QSPI_TARGET_PWRDN_EN on both bench and RTL to exercise the power-down build.
module tb_qspi_target;
    localparam int unsigned AW  = 10;
    localparam int unsigned RD  = 4;
    localparam int unsigned MSZ = 1 << AW;
`ifdef QSPI_TARGET_PWRDN_EN
    localparam bit AWAKE_RST = 1'b0;
`else
    localparam bit AWAKE_RST = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    qspi_target_if bus ();

    qspi_target #(.MEM_AW(AW), .READ_DELAY(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  model_mem [MSZ];
    bit          model_quad;
    bit          model_awake;
    logic [7:0]  wq[$];

    task automatic beat(input logic [3:0] nib);
        bus.io_in = nib;
        bus.cs_n  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic deselect();
        bus.cs_n  = 1'b1;
        bus.io_in = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        if (model_quad) begin
            beat(c[7:4]);
            beat(c[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) beat({3'($urandom), c[i]});
        end
        if (model_awake) begin
            if (c == 8'h35) model_quad = 1'b1;
            if (c == 8'hF5) model_quad = 1'b0;
        end
`ifdef QSPI_TARGET_PWRDN_EN
        if (c == 8'hAB) model_awake = 1'b1;
`endif
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) beat(a[i*4 +: 4]);
    endtask

    task automatic write_txn(input logic [23:0] a);
        bit awake_at_start;
        awake_at_start = model_awake;
        send_cmd(8'h38);
        send_addr(a);
        for (int k = 0; k < wq.size(); k++) begin
            beat(wq[k][7:4]);
            beat(wq[k][3:0]);
            if (awake_at_start) model_mem[(int'(a) + k) % MSZ] = wq[k];
        end
        deselect();
    endtask

    task automatic read_check(input string tag, input logic [23:0] a, input int nbytes);
        logic [7:0] b;
        logic [3:0] exp;
        send_cmd(8'hEB);
        send_addr(a);
        for (int i = 0; i < 2 + RD; i++) begin
            n_vec++;
            if (bus.io_oe !== 4'h0) begin
                n_err++;
                $display("FAIL %s pre-data io_oe (beat %0d): got %h, expected 0", tag, i, bus.io_oe);
            end
            beat(4'($urandom));
        end
        for (int k = 0; k < 2 * nbytes; k++) begin
            b   = model_mem[(int'(a) + k / 2) % MSZ];
            exp = (k % 2 == 0) ? b[7:4] : b[3:0];
            n_vec++;
            if (bus.io_oe !== 4'hF || bus.io_out !== exp) begin
                n_err++;
                $display("FAIL %s nibble %0d @%h: got oe=%h out=%h, expected oe=f out=%h",
                         tag, k, a, bus.io_oe, bus.io_out, exp);
            end
            if (k != 2 * nbytes - 1) beat(4'($urandom));
        end
        deselect();
        n_vec++;
        if (bus.io_oe !== 4'h0 || bus.io_out !== 4'h0) begin
            n_err++;
            $display("FAIL %s after cs_n rise: got oe=%h out=%h, expected 0/0",
                     tag, bus.io_oe, bus.io_out);
        end
    endtask

    task automatic check_flags(input string tag);
        n_vec++;
        if (bus.quad !== model_quad || bus.awake !== model_awake) begin
            n_err++;
            $display("FAIL %s flags: got quad=%b awake=%b, expected quad=%b awake=%b",
                     tag, bus.quad, bus.awake, model_quad, model_awake);
        end
    endtask

    task automatic test_reset();
        logic [7:0] c;
        bus.cs_n  = 1'b0;
        bus.io_in = 4'h0;
        reset     = 1'b1;
        model_quad  = 1'b0;
        model_awake = AWAKE_RST;
        #23;
        n_vec++;
        if (bus.io_oe !== 4'h0 || bus.io_out !== 4'h0) begin
            n_err++;
            $display("FAIL reset outputs: got oe=%h out=%h, expected 0/0", bus.io_oe, bus.io_out);
        end
        check_flags("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        // cs_n never rose since reset, so this 0x35 must be ignored
        c = 8'h35;
        for (int i = 7; i >= 0; i--) beat({3'b000, c[i]});
        check_flags("reset_no_arm");
        deselect();
    endtask

`ifdef QSPI_TARGET_PWRDN_EN
    task automatic test_pwrdn();
        send_cmd(8'hAB);
        deselect();
        check_flags("pwrdn_wake1");
        wq = '{8'h5A};
        write_txn(24'h000123);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_awake = 1'b0;
        model_quad  = 1'b0;
        deselect();
        check_flags("pwrdn_asleep");
        wq = '{8'hC3};
        write_txn(24'h000123);
        send_cmd(8'h35);
        deselect();
        check_flags("pwrdn_quad_ignored");
        send_cmd(8'hAB);
        deselect();
        check_flags("pwrdn_wake2");
        read_check("pwrdn_kept", 24'h000123, 1);
        wq = '{8'hC3};
        write_txn(24'h000123);
        read_check("pwrdn_write", 24'h000123, 1);
    endtask
`endif

    task automatic test_fill();
        wq = {};
        for (int i = 0; i < MSZ; i++) wq.push_back(8'($urandom));
        write_txn(24'h000000);
        read_check("fill", 24'($urandom), 4);
    endtask

    task automatic test_serial_rw();
        wq = '{8'hA5, 8'h3C};
        write_txn(24'h000010);
        read_check("serial_rd", 24'h000010, 2);
    endtask

    task automatic test_quad_mode();
        send_cmd(8'h35);
        deselect();
        check_flags("quad_on");
        read_check("quad_rd", 24'h000010, 2);
        send_cmd(8'hAB);
        deselect();
        check_flags("quad_ab_noop");
        send_cmd(8'hF5);
        deselect();
        check_flags("quad_off");
    endtask

    task automatic test_wrap();
        wq = '{8'h11, 8'h22};
        write_txn(24'(MSZ - 1));
        read_check("wrap_rd", 24'(MSZ - 1), 2);
        read_check("wrap_zero", 24'h000000, 1);
        wq = '{8'h77};
        write_txn(24'h400010);
        read_check("alias", 24'h000010, 1);
    endtask

    task automatic test_abort();
        logic [23:0] a;
        logic [7:0]  d;
        a = 24'($urandom);
        d = 8'($urandom);
        send_cmd(8'h38);
        send_addr(a);
        beat(d[7:4]);
        beat(d[3:0]);
        beat(4'($urandom));
        deselect();
        model_mem[int'(a) % MSZ] = d;
        read_check("abort_write", a - 24'd1, 3);

        a = 24'($urandom);
        send_cmd(8'hEB);
        send_addr(a);
        for (int i = 0; i < 2 + RD; i++) beat(4'($urandom));
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (bus.io_oe !== 4'h0 || bus.io_out !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset_read: got oe=%h out=%h, expected 0/0", bus.io_oe, bus.io_out);
        end
        model_quad  = 1'b0;
        model_awake = AWAKE_RST;
        #2 reset = 1'b0;
        // cs_n still low from the aborted read: beats must be ignored
        for (int i = 0; i < 4; i++) beat(4'($urandom));
        n_vec++;
        if (bus.io_oe !== 4'h0) begin
            n_err++;
            $display("FAIL post_reset_ignore: got oe=%h, expected 0", bus.io_oe);
        end
        deselect();
        send_cmd(8'hAB);
        deselect();
        check_flags("post_reset");
        read_check("post_reset_mem", a, 2);
    endtask

    task automatic test_unknown();
        logic [23:0] a;
        send_cmd(8'h9F);
        for (int i = 0; i < 12; i++) begin
            beat(4'($urandom));
            n_vec++;
            if (bus.io_oe !== 4'h0 || bus.io_out !== 4'h0) begin
                n_err++;
                $display("FAIL unknown_cmd beat %0d: got oe=%h out=%h, expected 0/0",
                         i, bus.io_oe, bus.io_out);
            end
        end
        deselect();
        a = 24'h000010;
        read_check("after_unknown", a, 2);
    endtask

    task automatic test_random();
        logic [23:0] a;
        int          len;
        for (int it = 0; it < 8; it++) begin
            send_cmd(($urandom_range(0, 1) == 1) ? 8'h35 : 8'hF5);
            deselect();
            check_flags("rand_mode");
            a   = 24'($urandom);
            len = $urandom_range(1, 5);
            wq  = {};
            for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
            write_txn(a);
            read_check("rand_rw", a - 24'd1, len + 2);
        end
        send_cmd(8'hF5);
        deselect();
        check_flags("rand_end");
    endtask

    initial begin
        test_reset();
`ifdef QSPI_TARGET_PWRDN_EN
        test_pwrdn();
`endif
        test_fill();
        test_serial_rw();
        test_quad_mode();
        test_wrap();
        test_abort();
        test_unknown();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
